// File: rtl/bmp_ram_streamer_if.sv
// rtl/bmp_ram_streamer_if.sv - RAM read port and byte-stream bundle for bmp_ram_streamer
//
// Purpose: groups the result-RAM read port and the outgoing byte stream.
// Signals:
//   RAM_ren    streamer -> RAM   read enable
//   RAM_addr   streamer -> RAM   read address
//   RAM_out    RAM -> streamer   read data, valid one cycle after RAM_ren
//   out_valid  streamer -> sink  out_data holds a valid byte
//   out_ready  sink -> streamer  byte accepted when out_valid && out_ready
//   out_data   streamer -> sink  streamed byte
//   out_last   streamer -> sink  final byte of the image
// Modports: master = streamer side, slave = RAM + sink side.

interface bmp_ram_streamer_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20
);
  logic                  RAM_ren;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic [BYTE_WIDTH-1:0] RAM_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [BYTE_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output RAM_ren, RAM_addr,
    input  RAM_out,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  RAM_ren, RAM_addr,
    output RAM_out,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/bmp_ram_streamer.sv
// rtl/bmp_ram_streamer.sv - streams a BMP image (header + pixels) out of the result RAM
//
// Purpose: reads addresses 0..TOTAL_SIZE-1 from the result RAM in order and emits
//   each byte on a valid/ready stream. A 2-entry prefetch FIFO hides the one-cycle
//   RAM read latency and absorbs sink backpressure.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   start pulse, only sampled while idle
//   threshold  binarization level (only when BMP_BINARIZE_EN is defined)
//   done       one-cycle pulse after the final byte has been accepted
//   bus        bmp_ram_streamer_if.master: RAM read port + output byte stream
// Configuration macro: BMP_BINARIZE_EN - pixel bytes (address >= HEADER_SIZE) are
//   forced to all-ones / zero against threshold when they enter the FIFO.

module bmp_ram_streamer #(
  parameter int BYTE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 20,
  parameter int HEADER_SIZE = 54,
  parameter int TOTAL_SIZE  = 786486
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
`ifdef BMP_BINARIZE_EN
  input  logic [BYTE_WIDTH-1:0] threshold,
`endif
  output logic                  done,
  bmp_ram_streamer_if.master    bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Read issued last cycle; its data is on RAM_out this cycle.
  logic                  inflight_q;
  logic                  inflight_last_q;
`ifdef BMP_BINARIZE_EN
  logic                  inflight_hdr_q;
`endif

  logic [BYTE_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic                  ren;
  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;
  logic [BYTE_WIDTH-1:0] push_data;

  assign pop  = (count_q != 2'd0) && bus.out_ready;
  assign push = inflight_q;

  // Slots committed after this cycle: stored bytes plus the read in flight,
  // minus the byte leaving now. pop implies count_q >= 1, so no underflow.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

`ifdef BMP_BINARIZE_EN
  always_comb begin
    push_data = bus.RAM_out;
    if (!inflight_hdr_q) begin
      push_data = (bus.RAM_out >= threshold) ? {BYTE_WIDTH{1'b1}} : {BYTE_WIDTH{1'b0}};
    end
  end
`else
  assign push_data = bus.RAM_out;
`endif

  always_comb begin
    state_nxt = state_q;
    ren       = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) state_nxt = FETCH;
      end
      FETCH: begin
        ren = (occupancy < 3'd2);
        if (ren && (addr_q == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_last[rd_ptr_q]) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef BMP_BINARIZE_EN
      inflight_hdr_q  <= 1'b0;
`endif
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_nxt;
      inflight_q <= ren;

      if (ren) begin
        inflight_last_q <= (addr_q == LAST_ADDR);
`ifdef BMP_BINARIZE_EN
        inflight_hdr_q  <= (addr_q < ADDR_WIDTH'(HEADER_SIZE));
`endif
        // Address parks on the last byte; it is rewound when the frame ends.
        if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
      end else if (state_q == FINISH) begin
        addr_q <= '0;
      end

      if (push) begin
        fifo_data[wr_ptr_q] <= push_data;
        fifo_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.RAM_ren   = ren;
  assign bus.RAM_addr  = addr_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = fifo_data[rd_ptr_q];
  // The head slot keeps its tag after the frame drains, so qualify it.
  assign bus.out_last  = (count_q != 2'd0) && fifo_last[rd_ptr_q];

endmodule

// File: tb/tb_bmp_ram_streamer.sv
// tb/tb_bmp_ram_streamer.sv - scoreboard testbench for bmp_ram_streamer

module tb_bmp_ram_streamer;

  localparam int BW = 8;
  localparam int AW = 20;
  localparam int HS = 54;
  localparam int TS = 102;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic done;
`ifdef BMP_BINARIZE_EN
  logic [BW-1:0] threshold = 8'h80;
`endif

  bmp_ram_streamer_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  bmp_ram_streamer #(
    .BYTE_WIDTH (BW),
    .ADDR_WIDTH (AW),
    .HEADER_SIZE(HS),
    .TOTAL_SIZE (TS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
`ifdef BMP_BINARIZE_EN
    .threshold(threshold),
`endif
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] mem [TS];

  always @(posedge clk) begin
    if (bus.RAM_ren) bus.RAM_out <= mem[bus.RAM_addr];
  end

  int  n_checks = 0;
  int  n_fail   = 0;
  sb_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] exp_byte(input int i);
`ifdef BMP_BINARIZE_EN
    if (i >= HS) return (mem[i] >= threshold) ? 8'hFF : 8'h00;
`endif
    return mem[i];
  endfunction

  // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
  int            outstanding = 0;
  int            next_addr = 0;
  int            byte_count = 0;
  int            done_count = 0;
  int            cyc = 0;
  int            first_pop_cyc = 0;
  int            last_pop_cyc = 0;
  logic          done_pending = 1'b0;
  logic          stall_prev = 1'b0;
  logic [BW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;
  logic          pop_now;
  sb_t           e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      outstanding  = 0;
      next_addr    = 0;
      byte_count   = 0;
      done_pending = 1'b0;
      stall_prev   = 1'b0;
    end else begin
      pop_now = bus.out_valid && bus.out_ready;
      if (done || done_pending) check("done_pulse", done, done_pending);
      if (done) begin
        done_count++;
        byte_count = 0;
        next_addr  = 0;
      end
      done_pending = 1'b0;
      if (stall_prev) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, stall_data);
        check("stall_last", bus.out_last, stall_last);
      end
      if (bus.RAM_ren) begin
        check("ren_occupancy", (outstanding - int'(pop_now)) < 2, 1);
        check("ren_addr", bus.RAM_addr, next_addr);
        next_addr++;
      end
      if (pop_now) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", bus.out_last, e.last);
          if (byte_count == 0) first_pop_cyc = cyc;
          byte_count++;
          if (e.last) begin
            done_pending = 1'b1;
            last_pop_cyc = cyc;
          end
        end
      end
      stall_prev  = bus.out_valid && !bus.out_ready;
      stall_data  = bus.out_data;
      stall_last  = bus.out_last;
      outstanding = outstanding + int'(bus.RAM_ren) - int'(pop_now);
    end
  end

  task automatic push_frame();
    for (int i = 0; i < TS; i++) begin
      sb_t s;
      s.data = exp_byte(i);
      s.last = (i == TS - 1);
      sb.push_back(s);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the start edge.
  task automatic start_frame(input bit hold);
    push_frame();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_frame(input bit rand_rdy, input int d0);
    for (int c = 0; c < 3000 && done_count == d0; c++) begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.out_ready = 1'b1;
    in_valid      = 1'b0;
    check("frame_done", done_count - d0, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int d0;
    int bc;
    bus.out_ready = 1'b1;
    for (int i = 0; i < TS; i++) mem[i] = 8'(i);

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ren", bus.RAM_ren, 0);
    check("rst_addr", bus.RAM_addr, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2. full-rate frame with latency and bubble-free checks
    d0 = done_count;
    start_frame(1'b0);
    @(negedge clk);
    check("lat_c1_ren", bus.RAM_ren, 1);
    check("lat_c1_addr", bus.RAM_addr, 0);
    check("lat_c1_valid", bus.out_valid, 0);
    @(negedge clk);
    check("lat_c2_valid", bus.out_valid, 0);
    @(negedge clk);
    check("lat_c3_valid", bus.out_valid, 1);
    check("lat_c3_data", bus.out_data, 0);
    wait_frame(1'b0, d0);
    check("no_bubble_span", last_pop_cyc - first_pop_cyc + 1, TS);

    // 3. random backpressure
    d0 = done_count;
    start_frame(1'b0);
    wait_frame(1'b1, d0);

    // 4. in_valid held high through FETCH/DRAIN/FINISH
    d0 = done_count;
    start_frame(1'b1);
    wait_frame(1'b0, d0);
    repeat (10) @(posedge clk);
    #1;
    check("single_frame", done_count - d0, 1);
    check("idle_valid", bus.out_valid, 0);

    // 5. reset mid-frame, then restart
    start_frame(1'b0);
    bc = 0;
    for (int c = 0; c < 500 && bc < 40; c++) begin
      @(posedge clk);
      #1;
      bc = byte_count;
    end
    check("mid_reset_point", bc >= 40, 1);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_valid", bus.out_valid, 0);
    d0 = done_count;
    start_frame(1'b0);
    @(negedge clk);
    check("restart_ren", bus.RAM_ren, 1);
    check("restart_addr", bus.RAM_addr, 0);
    wait_frame(1'b0, d0);

    // 6. binarization boundary bytes (pass-through in the default build)
    mem[54] = 8'h7F;
    mem[55] = 8'h80;
    d0 = done_count;
    start_frame(1'b0);
    wait_frame(1'b1, d0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
